az_el_step_gen: RTL and testbench



---
 rtl/az_el_pkg.sv | 15 +
 rtl/az_el_step_gen_if.sv | 21 ++
 rtl/az_el_axis.sv | 93 +++++++++
 rtl/az_el_step_gen.sv | 95 +++++++++
 tb/tb_az_el_step_gen.sv | 234 +++++++++++++++++++++++
 5 files changed

// File: rtl/az_el_pkg.sv
// rtl/az_el_pkg.sv - shared axis state encoding and default widths for the az/el step generator
package az_el_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } axis_state_t;

    localparam int POS_W_DEF   = 16;
    localparam int DIV_W_DEF   = 16;
    localparam int PULSE_W_DEF = 4;

endpackage

// File: rtl/az_el_step_gen_if.sv
// rtl/az_el_step_gen_if.sv - command handshake from the register slave into the step generator
interface az_el_step_gen_if #(
    parameter int POS_W = 16,
    parameter int DIV_W = 16
);
    logic             cmd_valid;
    logic             cmd_ready;
    logic [POS_W-1:0] cmd_az_target;
    logic [POS_W-1:0] cmd_el_target;
    logic [DIV_W-1:0] cmd_period;

    modport master (
        output cmd_valid, cmd_az_target, cmd_el_target, cmd_period,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid, cmd_az_target, cmd_el_target, cmd_period,
        output cmd_ready
    );
endinterface

// File: rtl/az_el_axis.sv
// rtl/az_el_axis.sv - one axis: step FSM, period counter and absolute position register
module az_el_axis
    import az_el_pkg::*;
#(
    parameter int POS_W   = POS_W_DEF,
    parameter int DIV_W   = DIV_W_DEF,
    parameter int PULSE_W = PULSE_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [POS_W-1:0] target,
    input  logic [DIV_W-1:0] period,
    output logic             step,
    output logic             dir,
    output logic [POS_W-1:0] pos,
    output logic             idle_next
);

    localparam logic [DIV_W-1:0] PW_LAST = DIV_W'(PULSE_W - 1);

    axis_state_t      state;
    logic [POS_W-1:0] tgt;
    logic [DIV_W-1:0] per;
    logic [DIV_W-1:0] cnt;
    logic             period_end;
    logic [POS_W-1:0] pos_stepped;

    // cnt is zero on the HIGH entry cycle, so the next rising edge is due when cnt reaches per-1
    assign period_end  = (cnt == per - DIV_W'(1));
    assign pos_stepped = dir ? pos + POS_W'(1) : pos - POS_W'(1);

    assign idle_next = abort
                    || (state == IDLE && !(start && target != pos))
                    || (state == LOW && period_end && pos == tgt);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            tgt   <= '0;
            per   <= '0;
            cnt   <= '0;
            step  <= 1'b0;
            dir   <= 1'b0;
            pos   <= '0;
        end else if (abort) begin
            state <= IDLE;
            step  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        tgt <= target;
                        per <= period;
                        if (target != pos) begin
                            dir   <= (target > pos);
                            state <= SETUP;
                        end
                    end
                end
                SETUP: begin
                    state <= HIGH;
                    step  <= 1'b1;
                    cnt   <= '0;
                    pos   <= pos_stepped;
                end
                HIGH: begin
                    cnt <= cnt + DIV_W'(1);
                    if (cnt == PW_LAST) begin
                        step  <= 1'b0;
                        state <= LOW;
                    end
                end
                LOW: begin
                    if (period_end) begin
                        if (pos != tgt) begin
                            state <= HIGH;
                            step  <= 1'b1;
                            cnt   <= '0;
                            pos   <= pos_stepped;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt + DIV_W'(1);
                    end
                end
            endcase
        end
    end

endmodule

// File: rtl/az_el_step_gen.sv
// rtl/az_el_step_gen.sv - two-axis step/dir generator: handshake, period clamp, busy/done merge
// Optional soft limits on targets when AZ_EL_SOFT_LIMIT_EN is defined.
module az_el_step_gen
    import az_el_pkg::*;
#(
    parameter int POS_W   = POS_W_DEF,
    parameter int DIV_W   = DIV_W_DEF,
    parameter int PULSE_W = PULSE_W_DEF
`ifdef AZ_EL_SOFT_LIMIT_EN
    ,
    parameter logic [POS_W-1:0] AZ_MAX = {POS_W{1'b1}},
    parameter logic [POS_W-1:0] EL_MAX = {POS_W{1'b1}}
`endif
) (
    input  logic               ACLK,
    input  logic               ARESETN,
    az_el_step_gen_if.slave    cmd,
    input  logic               abort,
    output logic               az_step,
    output logic               el_step,
    output logic               az_dir,
    output logic               el_dir,
    output logic [POS_W-1:0]   az_pos,
    output logic [POS_W-1:0]   el_pos,
    output logic               busy,
    output logic               done
);

    localparam logic [DIV_W-1:0] MIN_PERIOD = DIV_W'(2 * PULSE_W);

    logic             ready_en;
    logic             accept;
    logic             az_idle_next;
    logic             el_idle_next;
    logic [DIV_W-1:0] eff_period;
    logic [POS_W-1:0] az_tgt;
    logic [POS_W-1:0] el_tgt;

    // holding ready low through the done cycle keeps the next accept strictly after done
    assign cmd.cmd_ready = ready_en && !busy && !done && !abort;
    assign accept        = cmd.cmd_valid && cmd.cmd_ready;
    assign eff_period    = (cmd.cmd_period < MIN_PERIOD) ? MIN_PERIOD : cmd.cmd_period;

`ifdef AZ_EL_SOFT_LIMIT_EN
    assign az_tgt = (cmd.cmd_az_target > AZ_MAX) ? AZ_MAX : cmd.cmd_az_target;
    assign el_tgt = (cmd.cmd_el_target > EL_MAX) ? EL_MAX : cmd.cmd_el_target;
`else
    assign az_tgt = cmd.cmd_az_target;
    assign el_tgt = cmd.cmd_el_target;
`endif

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            ready_en <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            ready_en <= 1'b1;
            done     <= 1'b0;
            if (accept) begin
                busy <= 1'b1;
            end else if (busy && az_idle_next && el_idle_next) begin
                busy <= 1'b0;
                done <= 1'b1;
            end
        end
    end

    az_el_axis #(.POS_W(POS_W), .DIV_W(DIV_W), .PULSE_W(PULSE_W)) u_az (
        .clk       (ACLK),
        .rst_n     (ARESETN),
        .start     (accept),
        .abort     (abort),
        .target    (az_tgt),
        .period    (eff_period),
        .step      (az_step),
        .dir       (az_dir),
        .pos       (az_pos),
        .idle_next (az_idle_next)
    );

    az_el_axis #(.POS_W(POS_W), .DIV_W(DIV_W), .PULSE_W(PULSE_W)) u_el (
        .clk       (ACLK),
        .rst_n     (ARESETN),
        .start     (accept),
        .abort     (abort),
        .target    (el_tgt),
        .period    (eff_period),
        .step      (el_step),
        .dir       (el_dir),
        .pos       (el_pos),
        .idle_next (el_idle_next)
    );

endmodule

// File: tb/tb_az_el_step_gen.sv
// tb/tb_az_el_step_gen.sv - directed self-checking bench for az_el_step_gen
module tb_az_el_step_gen;

    localparam int POS_W   = 16;
    localparam int DIV_W   = 16;
    localparam int PULSE_W = 4;

    logic             ACLK = 1'b0;
    logic             ARESETN = 1'b0;
    logic             abort = 1'b0;
    logic             az_step, el_step, az_dir, el_dir, busy, done;
    logic [POS_W-1:0] az_pos, el_pos;

    int checks   = 0;
    int failures = 0;
    int az_r[8];
    int el_r[8];

    int   done_k, n_az, n_el, waits, extra_done;
    logic dir_az, dir_el, busy1;

    always #5 ACLK = ~ACLK;

    az_el_step_gen_if #(.POS_W(POS_W), .DIV_W(DIV_W)) cmd ();

    az_el_step_gen #(
        .POS_W(POS_W), .DIV_W(DIV_W), .PULSE_W(PULSE_W)
`ifdef AZ_EL_SOFT_LIMIT_EN
        , .AZ_MAX(16'd5)
`endif
    ) dut (
        .ACLK    (ACLK),
        .ARESETN (ARESETN),
        .cmd     (cmd),
        .abort   (abort),
        .az_step (az_step),
        .el_step (el_step),
        .az_dir  (az_dir),
        .el_dir  (el_dir),
        .az_pos  (az_pos),
        .el_pos  (el_pos),
        .busy    (busy),
        .done    (done)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick;
        @(posedge ACLK);
        #1;
    endtask

    // Issue one command and follow it to done; k counts cycles after the accept edge (k=1 is N+1).
    task automatic run_cmd(input logic [15:0] az, input logic [15:0] el, input logic [15:0] per,
                           input int abort_k, input logic hold,
                           input logic [15:0] hold_az, input logic [15:0] hold_el);
        int   k;
        logic pa, pe;
        waits = 0;
        while (!cmd.cmd_ready && waits < 50) begin
            tick();
            waits++;
        end
        cmd.cmd_valid     = 1'b1;
        cmd.cmd_az_target = az;
        cmd.cmd_el_target = el;
        cmd.cmd_period    = per;
        tick();
        if (hold) begin
            cmd.cmd_az_target = hold_az;
            cmd.cmd_el_target = hold_el;
        end else begin
            cmd.cmd_valid = 1'b0;
        end
        k      = 1;
        busy1  = busy;
        dir_az = az_dir;
        dir_el = el_dir;
        pa     = az_step;
        pe     = el_step;
        n_az   = 0;
        n_el   = 0;
        done_k = -1;
        while (k < 400) begin
            if (done) begin
                done_k = k;
                break;
            end
            if (k == abort_k) begin
                abort = 1'b1;
                #1;
                check("abort_ready_low", cmd.cmd_ready, 0);
            end
            tick();
            abort = 1'b0;
            k++;
            if (az_step && !pa) begin
                if (n_az < 8) az_r[n_az] = k;
                n_az++;
            end
            if (el_step && !pe) begin
                if (n_el < 8) el_r[n_el] = k;
                n_el++;
            end
            pa = az_step;
            pe = el_step;
        end
    endtask

    initial begin
        cmd.cmd_valid     = 1'b0;
        cmd.cmd_az_target = '0;
        cmd.cmd_el_target = '0;
        cmd.cmd_period    = '0;
        repeat (2) tick();
        check("rst_ready", cmd.cmd_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_steps", {az_step, el_step}, 0);
        check("rst_dirs", {az_dir, el_dir}, 0);
        check("rst_az_pos", az_pos, 0);
        check("rst_el_pos", el_pos, 0);
        ARESETN = 1'b1;
        tick();
        check("ready_after_rst", cmd.cmd_ready, 1);

        // az 0->3 at period 10
        run_cmd(16'd3, 16'd0, 16'd10, 0, 1'b0, 16'd0, 16'd0);
        check("t1_busy_n1", busy1, 1);
        check("t1_az_dir", dir_az, 1);
        check("t1_n_az", n_az, 3);
        check("t1_rise0", az_r[0], 2);
        check("t1_rise1", az_r[1], 12);
        check("t1_rise2", az_r[2], 22);
        check("t1_n_el", n_el, 0);
        check("t1_done_k", done_k, 32);
        check("t1_busy_at_done", busy, 0);
        check("t1_az_pos", az_pos, 3);
        check("t1_el_pos", el_pos, 0);
        check("t1_ready_at_done", cmd.cmd_ready, 0);
        tick();
        check("t1_ready_after", cmd.cmd_ready, 1);
        check("t1_done_single", done, 0);

        // period 1 clamps to 8; az down, el up
        run_cmd(16'd1, 16'd2, 16'd1, 0, 1'b0, 16'd0, 16'd0);
        check("t2_az_dir", dir_az, 0);
        check("t2_el_dir", dir_el, 1);
        check("t2_n_az", n_az, 2);
        check("t2_n_el", n_el, 2);
        check("t2_az_rise1", az_r[1], 10);
        check("t2_el_rise1", el_r[1], 10);
        check("t2_done_k", done_k, 18);
        check("t2_az_pos", az_pos, 1);
        check("t2_el_pos", el_pos, 2);

        // targets equal to current positions
        run_cmd(16'd1, 16'd2, 16'd10, 0, 1'b0, 16'd0, 16'd0);
        check("t3_busy_n1", busy1, 1);
        check("t3_done_k", done_k, 2);
        check("t3_no_steps", n_az + n_el, 0);

        // abort while second az pulse is high (high at k=12..15)
        run_cmd(16'd5, 16'd2, 16'd10, 13, 1'b0, 16'd0, 16'd0);
        check("t4_done_k", done_k, 14);
        check("t4_step_low", az_step, 0);
        check("t4_n_az", n_az, 2);
        check("t4_az_pos", az_pos, 3);
        check("t4_busy", busy, 0);
        extra_done = 0;
        tick();
        check("t4_ready_after", cmd.cmd_ready, 1);
        repeat (3) begin
            if (done) extra_done++;
            tick();
        end
        check("t4_one_done", extra_done, 0);
        check("t4_pos_hold", az_pos, 3);

        // cmd_valid held with other targets during a move is ignored until after done
        run_cmd(16'd4, 16'd2, 16'd8, 0, 1'b1, 16'd0, 16'd0);
        check("t5_n_az", n_az, 1);
        check("t5_done_k", done_k, 10);
        check("t5_az_pos", az_pos, 4);
        run_cmd(16'd0, 16'd0, 16'd8, 0, 1'b0, 16'd0, 16'd0);
        check("t5_wait", waits, 1);
        check("t5b_n_az", n_az, 4);
        check("t5b_n_el", n_el, 2);
        check("t5b_done_k", done_k, 34);
        check("t5b_pos", {az_pos, el_pos}, 0);

`ifdef AZ_EL_SOFT_LIMIT_EN
        run_cmd(16'd9, 16'd0, 16'd8, 0, 1'b0, 16'd0, 16'd0);
        check("t6_n_az", n_az, 5);
        check("t6_az_pos", az_pos, 5);
        check("t6_done_k", done_k, 42);
        tick();
        run_cmd(16'd0, 16'd0, 16'd8, 0, 1'b0, 16'd0, 16'd0);
`endif

        // asynchronous reset in the middle of a move
        tick();
        cmd.cmd_valid     = 1'b1;
        cmd.cmd_az_target = 16'd2;
        cmd.cmd_el_target = 16'd2;
        cmd.cmd_period    = 16'd20;
        tick();
        cmd.cmd_valid = 1'b0;
        repeat (3) tick();
        check("t7_pre_az_pos", az_pos, 1);
        check("t7_pre_step", az_step, 1);
        #2;
        ARESETN = 1'b0;
        #1;
        check("t7_rst_az_pos", az_pos, 0);
        check("t7_rst_el_pos", el_pos, 0);
        check("t7_rst_busy", busy, 0);
        check("t7_rst_step", {az_step, el_step}, 0);
        tick();
        ARESETN = 1'b1;
        tick();
        check("t7_ready", cmd.cmd_ready, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
